// File: rtl/ifu_idu_pipe_buf.sv
// ifu_idu_pipe_buf
// ----------------
// Elastic IF/ID pipeline buffer. Fetched beats (inst, pc, pc+4 and a fault
// flag derived from the fetch bus response) are captured on a valid/ready
// handshake and handed to decode strictly in order. A small circular queue
// decouples fetch-side stalls from decode-side stalls. A redirect (flush)
// throws away every buffered beat and the beat being offered that cycle.
//
// Ports:
//   clk, rstn          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready  fetch-side handshake
//   in_inst, in_pc,    fetched beat payload
//   in_pcplus4, in_resp  (in_resp nonzero marks an access fault)
//   flush              control-flow redirect, drops all beats
//   out_valid/out_ready decode-side handshake
//   out_inst, out_pc,  head entry payload
//   out_pcplus4, out_fault
//   occupancy          number of valid entries
//   flush_drops        saturating count of entries discarded by flush

module ifu_idu_pipe_buf #(
    parameter int DATA_WIDTH  = 32,
    parameter int ACERR_WIDTH = 2,
    parameter int DEPTH       = 2,
    parameter int CNT_W       = 2
) (
    input  logic                   clk,
    input  logic                   rstn,

    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_inst,
    input  logic [DATA_WIDTH-1:0]  in_pc,
    input  logic [DATA_WIDTH-1:0]  in_pcplus4,
    input  logic [ACERR_WIDTH-1:0] in_resp,

    input  logic                   flush,

    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_inst,
    output logic [DATA_WIDTH-1:0]  out_pc,
    output logic [DATA_WIDTH-1:0]  out_pcplus4,
    output logic                   out_fault,

    output logic [CNT_W-1:0]       occupancy,
    output logic [7:0]             flush_drops
);

    localparam int              PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Storage, one array per field so each can be indexed independently.
    logic [DATA_WIDTH-1:0] inst_mem  [DEPTH];
    logic [DATA_WIDTH-1:0] pc_mem    [DEPTH];
    logic [DATA_WIDTH-1:0] pcp4_mem  [DEPTH];
    logic [DEPTH-1:0]      fault_mem;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic push;
    logic pop;
    logic [8:0] drop_sum;

    // Handshake qualifiers. Readiness depends only on registered occupancy,
    // never on out_ready, so a full buffer does not pass a beat straight
    // through; that keeps decode stalls from reaching fetch combinationally.
    // Flush masks both sides so nothing moves during a redirect cycle.
    assign in_ready  = rstn & ~flush & (occupancy != FULL_CNT);
    assign out_valid = (occupancy != '0) & ~flush;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Head entry is always presented; the fault flag is qualified by valid
    // so decode never sees a stale fault on an empty slot.
    assign out_inst    = inst_mem[rd_ptr];
    assign out_pc      = pc_mem[rd_ptr];
    assign out_pcplus4 = pcp4_mem[rd_ptr];
    assign out_fault   = fault_mem[rd_ptr] & out_valid;

    // Dropped-entry accumulation is one bit wider than the counter so the
    // carry tells us when to clamp at 255.
    assign drop_sum = {1'b0, flush_drops} + 9'(occupancy);

    // Pointer and occupancy bookkeeping. Flush wins over everything and
    // rewinds both pointers to zero; otherwise each side advances on its own
    // handshake and the occupancy only changes when exactly one side moves.
    // DEPTH is a power of two, so pointer wrap is plain overflow.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occupancy <= occupancy + CNT_W'(1);
                2'b01:   occupancy <= occupancy - CNT_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Flush statistics: every redirect adds however many entries it threw
    // away, clamping at the top instead of wrapping. An empty flush adds 0.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            flush_drops <= '0;
        end else if (flush) begin
            flush_drops <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end

    // Entry storage. Cleared on reset so the head outputs read as zero while
    // reset is held and after it releases. Writes only happen on an accepted
    // beat, which already excludes flush cycles.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                inst_mem[i] <= '0;
                pc_mem[i]   <= '0;
                pcp4_mem[i] <= '0;
            end
            fault_mem <= '0;
        end else if (push) begin
            inst_mem[wr_ptr]  <= in_inst;
            pc_mem[wr_ptr]    <= in_pc;
            pcp4_mem[wr_ptr]  <= in_pcplus4;
            fault_mem[wr_ptr] <= (in_resp != '0);
        end
    end

endmodule

// File: doc/ifu_idu_pipe_buf.md
Name: ifu_idu_pipe_buf

Overview:
Elastic IF/ID pipeline buffer between the instruction fetch unit and the decode unit. It captures each fetched beat (inst, pc, pc+4, fetch response) on a valid/ready handshake and presents it to decode in order. It decouples fetch-bus stalls from decode stalls and discards in-flight beats on a control-flow redirect (flush).

Parameters:
DATA_WIDTH, 32, width of inst/pc/pcplus4
ACERR_WIDTH, 2, width of fetch bus response code
DEPTH, 2, number of entries; power of two, >=2
CNT_W, 2, occupancy counter width = log2(DEPTH)+1

Ports:
clk  in  1  system clock, rising edge
rstn  in  1  asynchronous active-low reset
in_valid  in  1  fetch beat valid (from IFU Ivalid)
in_ready  out  1  buffer can accept a beat this cycle
in_inst  in  DATA_WIDTH  fetched instruction word
in_pc  in  DATA_WIDTH  PC of the fetched instruction
in_pcplus4  in  DATA_WIDTH  PC+4 of the fetched instruction
in_resp  in  ACERR_WIDTH  fetch bus response; nonzero = access fault
flush  in  1  redirect: drop all buffered beats and the current input beat
out_valid  out  1  head entry valid for decode
out_ready  in  1  decode accepts head entry
out_inst  out  DATA_WIDTH  head instruction
out_pc  out  DATA_WIDTH  head PC
out_pcplus4  out  DATA_WIDTH  head PC+4
out_fault  out  1  head entry carried nonzero in_resp
occupancy  out  CNT_W  number of valid entries
flush_drops  out  8  saturating count of entries discarded by flush

Behaviour:
- Reset (rstn=0, asynchronous): wr_ptr=rd_ptr=0, occupancy=0, flush_drops=0; out_valid=0, in_ready=0 while in reset; out_inst/out_pc/out_pcplus4=0, out_fault=0. Storage array need not be cleared.
- Push: in_valid & in_ready at the rising edge -> write {inst,pc,pcplus4,(in_resp!=0)} at wr_ptr; wr_ptr+1 mod DEPTH.
- Pop: out_valid & out_ready at the rising edge -> rd_ptr+1 mod DEPTH.
- in_ready = rstn & ~flush & (occupancy != DEPTH). No pass-through when full, even if out_ready=1, so there is no comb path out_ready->in_ready.
- out_valid = (occupancy != 0) & ~flush. out_* driven from entry[rd_ptr]; when out_valid=0, out_* hold entry[rd_ptr] (don't-care), and out_fault is forced 0.
- Latency: a beat pushed at edge N is visible on out_* after edge N; minimum 1 cycle. There is no bypass when empty.
- Simultaneous push and pop (occupancy 1..DEPTH-1): occupancy unchanged, both pointers advance.
- Occupancy: +1 on push only, -1 on pop only; never exceeds DEPTH and never underflows. Pointers wrap modulo DEPTH.
- Flush (sampled at the edge): highest priority. Next state occupancy=0, wr_ptr=rd_ptr=0. No push or pop occurs that cycle because in_ready and out_valid are forced low. flush_drops += occupancy, saturating at 255. Flush with occupancy 0 leaves the counter unchanged.
- Consecutive flush cycles: each drains nothing further; the buffer is empty after the first.
- Fault beats are buffered and ordered like normal beats; decode interprets out_fault.
- Reset asserted mid-operation: all state returns to reset values immediately, without waiting for clk.
- Handshake rules: out_* stay stable while out_valid=1 and out_ready=0, except when flush drops the entry. The upstream is expected to hold in_* while in_valid=1 and in_ready=0. The buffer itself does not check this.

Test Plan:
- Reset then single beat: in_inst=0x00000013, in_pc=0x80000000, in_pcplus4=0x80000004, out_ready=1 -> out_valid rises the cycle after acceptance with those values, out_fault=0, occupancy returns to 0 after the pop.
- Fill and backpressure: out_ready=0, push 3 beats with pc 0x80000000/04/08 -> first two accepted, in_ready=0 with occupancy=2, third held; raise out_ready -> outputs pop in order 0x80000000, 0x80000004, 0x80000008.
- Streaming: in_valid=out_ready=1 for 10 cycles with pc incrementing by 4 -> one beat per cycle after the first, no gaps, occupancy constant at 1, pointers wrap correctly.
- Flush with 2 entries and in_valid=1: flush for 1 cycle -> occupancy=0, out_valid=0 next cycle, incoming beat not stored, flush_drops=2. Next beat pc=0x80000100 is the next output.
- Fault propagation: push with in_resp=2'b10 -> out_fault=1 for that entry only; the following beat with in_resp=0 gives out_fault=0.
- Async reset mid-stream: drop rstn between clock edges with occupancy=2 -> out_valid=0 and occupancy=0 immediately, flush_drops=0, and nothing is output after rstn releases until a new push.
